// File: rtl/prog_clk_divider_pkg.sv
// clk_div_pkg: shared constants, FSM state type and ratio helpers for the programmable clock divider
package clk_div_pkg;
  localparam int unsigned MIN_DIV = 2;
  localparam int unsigned DEFAULT_DIV_C = 18;
  typedef enum logic [1:0] {STOPPED, LOW, HIGH} div_state_t;
  function automatic int unsigned clamp_div(int unsigned v);
    return v < MIN_DIV ? MIN_DIV : v;
  endfunction
  function automatic int unsigned lo_len(int unsigned n);
    return n >> 1;
  endfunction
  function automatic int unsigned hi_len(int unsigned n);
    return (n + 1) >> 1;
  endfunction
endpackage

// File: rtl/div_phase_counter.sv
// div_phase_counter: phase counter that wraps to zero at a programmable terminal value
module div_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == term;
  // hold at zero while cleared, otherwise count and wrap on terminal count
  always_comb cnt_d = (clr || tc) ? '0 : cnt_q + 1'b1;
  // counter register
  always_ff @(posedge clk_in or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: runtime-programmable integer clock divider with glitch-free ratio changes and tick strobe
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] div_cur,
  output logic             load_pending
);
  div_state_t state_q, state_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d, pend_v_q, pend_v_d, term;
  logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, tc, boundary;
  div_phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_in(clk_in),
    .reset (reset),
    .clr   (state_q == STOPPED),
    .term  (term),
    .tc    (tc)
  );
  // state register
  always_ff @(posedge clk_in or posedge reset)
    if (reset) state_q <= LOW;
    else state_q <= state_d;
  // next state: phases end only on terminal count, so enable never truncates a period
  always_comb
    state_d = state_q == STOPPED ? (enable ? LOW : STOPPED) :
              !tc ? state_q :
              state_q == LOW ? HIGH : (enable ? LOW : STOPPED);
  // outputs: phase terminal, boundary detection and next output flop values
  always_comb begin
    term = state_q == HIGH ? CNT_W'(hi_len(32'(div_cur_q)) - 1) : CNT_W'(lo_len(32'(div_cur_q)) - 1);
    boundary = state_q == STOPPED || (state_q == HIGH && tc);
    clk_d = state_d == HIGH;
    tick_d = state_q == LOW && tc;
  end
  // ratio path: last load wins, the pending value seen before the boundary edge is applied
  always_comb begin
    pend_v_d = div_load ? CNT_W'(clamp_div(32'(div_val))) : pend_v_q;
    pend_d = div_load || (pend_q && !boundary);
    div_cur_d = (boundary && pend_q) ? pend_v_q : div_cur_q;
  end
  // ratio registers and output flops
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      div_cur_q <= CNT_W'(DEFAULT_DIV);
      pend_v_q <= CNT_W'(DEFAULT_DIV);
      pend_q <= 1'b0;
      clk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      div_cur_q <= div_cur_d;
      pend_v_q <= pend_v_d;
      pend_q <= pend_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
    end
  assign clk_out = clk_q;
  assign tick = tick_q;
  assign running = state_q != STOPPED;
  assign div_cur = div_cur_q;
  assign load_pending = pend_q;
endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: directed scoreboard bench for the programmable clock divider
module tb_prog_clk_divider;
  logic clk_in = 1'b0, reset, enable, div_load;
  logic [7:0] div_val, div_cur;
  logic clk_out, tick, running, load_pending;
  int errors = 0, checks = 0, e = 0;
  typedef struct {
    int at;
    logic c, t, p, r;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];

  prog_clk_divider dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .div_val     (div_val),
    .div_load    (div_load),
    .clk_out     (clk_out),
    .tick        (tick),
    .running     (running),
    .div_cur     (div_cur),
    .load_pending(load_pending)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL timeout: edge %0d reached, bench did not complete", e);
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(int at, logic c, logic t, logic p, logic [7:0] d, logic r);
    exp_t x;
    x.at = at; x.c = c; x.t = t; x.p = p; x.d = d; x.r = r;
    sb.push_back(x);
  endtask

  task automatic check_all(string tag, logic c, logic t, logic p, logic [7:0] d, logic r);
    chk({tag, " clk_out"}, 8'(clk_out), 8'(c));
    chk({tag, " tick"}, 8'(tick), 8'(t));
    chk({tag, " load_pending"}, 8'(load_pending), 8'(p));
    chk({tag, " div_cur"}, div_cur, d);
    chk({tag, " running"}, 8'(running), 8'(r));
  endtask

  task automatic edge_step();
    exp_t x;
    @(posedge clk_in);
    #1;
    e++;
    while (sb.size() > 0 && sb[0].at <= e) begin
      x = sb.pop_front();
      if (x.at < e) chk($sformatf("stale@%0d", x.at), 8'(e), 8'(x.at));
      else check_all($sformatf("edge%0d", e), x.c, x.t, x.p, x.d, x.r);
    end
  endtask

  task automatic run_to(int n);
    while (e < n) edge_step();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; div_load = 1'b0; div_val = 8'd0;
    @(posedge clk_in);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 8'd18, 1'b1);
    @(negedge clk_in);
    reset = 1'b0;
    e = 0;
    push(8, 0, 0, 0, 18, 1); push(9, 1, 1, 0, 18, 1); push(10, 1, 0, 0, 18, 1);
    push(17, 1, 0, 0, 18, 1); push(18, 0, 0, 0, 18, 1); push(26, 0, 0, 0, 18, 1);
    push(27, 1, 1, 0, 18, 1); push(28, 1, 0, 0, 18, 1); push(36, 0, 0, 0, 18, 1);
    push(45, 1, 1, 0, 18, 1);
    run_to(46);
    div_val = 8'd5; div_load = 1'b1;
    push(47, 1, 0, 1, 18, 1);
    edge_step();
    div_load = 1'b0;
    push(53, 1, 0, 1, 18, 1); push(54, 0, 0, 0, 5, 1); push(55, 0, 0, 0, 5, 1);
    push(56, 1, 1, 0, 5, 1); push(57, 1, 0, 0, 5, 1); push(58, 1, 0, 0, 5, 1);
    push(59, 0, 0, 0, 5, 1); push(61, 1, 1, 0, 5, 1); push(64, 0, 0, 0, 5, 1);
    run_to(64);
    div_val = 8'd1; div_load = 1'b1;
    push(65, 0, 0, 1, 5, 1);
    edge_step();
    div_load = 1'b0;
    push(66, 1, 1, 1, 5, 1); push(69, 0, 0, 0, 2, 1); push(70, 1, 1, 0, 2, 1);
    push(71, 0, 0, 0, 2, 1); push(72, 1, 1, 0, 2, 1); push(73, 0, 0, 0, 2, 1);
    run_to(73);
    div_val = 8'd0; div_load = 1'b1;
    push(74, 1, 1, 1, 2, 1);
    edge_step();
    div_load = 1'b0;
    push(75, 0, 0, 0, 2, 1); push(76, 1, 1, 0, 2, 1); push(77, 0, 0, 0, 2, 1);
    run_to(77);
    div_val = 8'd3; div_load = 1'b1;
    push(78, 1, 1, 1, 2, 1);
    edge_step();
    div_val = 8'd4;
    push(79, 0, 0, 1, 3, 1);
    edge_step();
    div_load = 1'b0;
    push(80, 1, 1, 1, 3, 1); push(81, 1, 0, 1, 3, 1); push(82, 0, 0, 0, 4, 1);
    run_to(82);
    div_val = 8'd6; div_load = 1'b1;
    push(83, 0, 0, 1, 4, 1);
    edge_step();
    div_val = 8'd10;
    push(84, 1, 1, 1, 4, 1);
    edge_step();
    div_load = 1'b0;
    push(85, 1, 0, 1, 4, 1); push(86, 0, 0, 0, 10, 1); push(91, 1, 1, 0, 10, 1);
    push(92, 1, 0, 0, 10, 1); push(95, 1, 0, 0, 10, 1); push(96, 0, 0, 0, 10, 1);
    push(101, 1, 1, 0, 10, 1);
    run_to(102);
    enable = 1'b0;
    push(103, 1, 0, 0, 10, 1); push(105, 1, 0, 0, 10, 1); push(106, 0, 0, 0, 10, 0);
    push(107, 0, 0, 0, 10, 0);
    run_to(107);
    div_val = 8'd4; div_load = 1'b1;
    push(108, 0, 0, 1, 10, 0);
    edge_step();
    div_load = 1'b0;
    push(109, 0, 0, 0, 4, 0); push(110, 0, 0, 0, 4, 0);
    run_to(110);
    enable = 1'b1;
    push(111, 0, 0, 0, 4, 1); push(112, 0, 0, 0, 4, 1); push(113, 1, 1, 0, 4, 1);
    push(114, 1, 0, 0, 4, 1); push(115, 0, 0, 0, 4, 1); push(117, 1, 1, 0, 4, 1);
    run_to(117);
    div_val = 8'd7; div_load = 1'b1;
    push(118, 1, 0, 1, 4, 1);
    edge_step();
    div_load = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_all("async_reset", 1'b0, 1'b0, 1'b0, 8'd18, 1'b1);
    @(negedge clk_in);
    reset = 1'b0;
    chk("queue_empty_at_reset", 8'(sb.size()), 8'd0);
    sb.delete();
    e = 0;
    push(8, 0, 0, 0, 18, 1); push(9, 1, 1, 0, 18, 1); push(17, 1, 0, 0, 18, 1);
    push(18, 0, 0, 0, 18, 1); push(27, 1, 1, 0, 18, 1);
    run_to(28);
    chk("queue_drained", 8'(sb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
